// File: rtl/program_loader.sv
// Boot loader: takes a byte stream (header word N followed by N words), assembles
// little-endian 32-bit words, writes them to CPU memory from BASE_ADDR upward and
// holds the CPU in reset until the last word has been written.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_W = MAX_WORDS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;     // bytes 0..2 of the word in progress
    logic [31:0] n_q, n_d;             // latched word count
    logic [31:0] idx_q, idx_d;         // index of the word being written
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rx_ready_q, rx_ready_d;
    logic        mem_we_q, mem_we_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic [31:0] word_in;

    assign accept  = rx_valid && rx_ready_q;
    // The 4th byte completes the word together with the three already held.
    assign word_in = {rx_data, shift_q};

    // Next-state logic; outputs are derived from the next state so they register
    // in step with the state they belong to.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        n_d         = n_q;
        idx_d       = idx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    shift_d    = 24'd0;
                    idx_d      = 32'd0;
                end
            end
            S_LEN, S_DATA: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        if (state_q == S_LEN) begin
                            if (word_in == 32'd0 || word_in > MAX_W) begin
                                state_d = S_ERR;
                            end else begin
                                n_d     = word_in;
                                state_d = S_DATA;
                            end
                        end else begin
                            state_d     = S_WRITE;
                            mem_addr_d  = BASE_ADDR + (idx_q << 2);
                            mem_wdata_d = word_in;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0:    shift_d[7:0]   = rx_data;
                            2'd1:    shift_d[15:8]  = rx_data;
                            2'd2:    shift_d[23:16] = rx_data;
                            default: shift_d        = shift_q;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == n_q - 32'd1) begin
                    state_d = S_RUN;
                end else begin
                    idx_d   = idx_q + 32'd1;
                    state_d = S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d  = (state_d == S_LEN) || (state_d == S_DATA);
        mem_we_d    = (state_d == S_WRITE);
        cpu_reset_d = (state_d == S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERR);
    end

    // State and registered outputs; reset abandons any partial load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            n_q         <= 32'd0;
            idx_q       <= 32'd0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte-stream loads, header errors, reset
// mid-load, restart from RUN and ignored start pulses.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_reset, done, error;
    logic [31:0] mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    // captured write transactions
    int          nw = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic        wr_rdy  [0:63];

    program_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every write strobe, with rx_ready seen in that same cycle.
    always @(negedge clk) begin
        if (mem_we && nw < 64) begin
            wr_addr[nw] = mem_addr;
            wr_data[nw] = mem_wdata;
            wr_rdy[nw]  = rx_ready;
            nw = nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL byte_timeout: got rx_ready=0 expected rx_ready=1 within 50 cycles");
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_done"},      {31'd0, done},      32'd0);
        chk({tag, "_error"},     {31'd0, error},     32'd0);
        chk({tag, "_mem_addr"},  mem_addr,           32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata,          32'h0);
    endtask

    initial begin
        int base;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);

        // ---- test 1: single word load
        pulse_start();
        chk("len_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_word(32'h0000_0001, 0);
        send_word(32'h0050_0513, 0);
        chk("t1_mem_we",    {31'd0, mem_we},    32'd1);
        chk("t1_addr",      mem_addr,           32'h0);
        chk("t1_wdata",     mem_wdata,          32'h0050_0513);
        chk("t1_write_rdy", {31'd0, rx_ready},  32'd0);
        chk("t1_cpu_low",   {31'd0, cpu_reset}, 32'd0);
        @(negedge clk);
        chk("t1_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t1_done",      {31'd0, done},      32'd1);
        chk("t1_we_drop",   {31'd0, mem_we},    32'd0);
        chk("t1_nwrites",   nw,                 32'd1);

        // ---- test 5a / 2: restart from RUN, N=3 with random gaps
        pulse_start();
        chk("t5_cpu_drop",  {31'd0, cpu_reset}, 32'd0);
        chk("t5_done_drop", {31'd0, done},      32'd0);
        base = nw;
        send_word(32'd3, 3);
        send_word(32'h1111_1111, 3);
        send_word(32'h2222_2222, 3);
        send_word(32'h3333_3333, 3);
        @(negedge clk);
        chk("t2_nwrites", nw - base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_addr%0d", i), wr_addr[base + i], 32'(4 * i));
            chk($sformatf("t2_data%0d", i), wr_data[base + i], {4{8'(8'h11 * (i + 1))}});
            chk($sformatf("t2_rdy%0d", i),  {31'd0, wr_rdy[base + i]}, 32'd0);
        end
        chk("t2_done", {31'd0, done}, 32'd1);

        // ---- test 3: bad headers
        base = nw;
        pulse_start();
        send_word(32'd0, 0);
        chk("t3_err_n0",   {31'd0, error},     32'd1);
        chk("t3_cpu_n0",   {31'd0, cpu_reset}, 32'd0);
        chk("t3_rdy_n0",   {31'd0, rx_ready},  32'd0);
        pulse_start();
        chk("t3_err_clr1", {31'd0, error},     32'd0);
        send_word(32'd1025, 0);
        chk("t3_err_big",  {31'd0, error},     32'd1);
        repeat (3) @(negedge clk);
        chk("t3_err_sticky", {31'd0, error},   32'd1);
        chk("t3_no_write", nw - base,          32'd0);
        pulse_start();
        chk("t3_err_clr2", {31'd0, error},     32'd0);
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 1);
        @(negedge clk);
        chk("t3_nw",    nw - base,        32'd1);
        chk("t3_addr",  wr_addr[base],    32'h0);
        chk("t3_data",  wr_data[base],    32'hDEAD_BEEF);
        chk("t3_done",  {31'd0, done},    32'd1);

        // ---- test 4: reset after 6 bytes of an N=2 load
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        #1;
        chk_reset_vals("t4");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = nw;
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'hCAFE_0001, 2);
        send_word(32'hCAFE_0002, 2);
        @(negedge clk);
        chk("t4_nw",    nw - base,          32'd2);
        chk("t4_addr0", wr_addr[base],      32'h0);
        chk("t4_data0", wr_data[base],      32'hCAFE_0001);
        chk("t4_addr1", wr_addr[base + 1],  32'h4);
        chk("t4_data1", wr_data[base + 1],  32'hCAFE_0002);
        chk("t4_done",  {31'd0, done},      32'd1);

        // ---- test 5b: start during DATA is ignored
        base = nw;
        pulse_start();
        send_word(32'd1, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        pulse_start();
        chk("t5_still_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        @(negedge clk);
        chk("t5_nw",   nw - base,      32'd1);
        chk("t5_addr", wr_addr[base],  32'h0);
        chk("t5_data", wr_data[base],  32'h1234_5678);
        chk("t5_done", {31'd0, done},  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
